// File: rtl/sb_uart_tx_slave_pkg.sv
// sb_uart_tx_slave_pkg: register offsets, STATUS bit indices and TX FSM states
package sb_uart_tx_slave_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int STOP_CLR = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/sb_uart_tx_slave_fifo.sv
// sb_sync_fifo: synchronous FIFO with MSB-compare wrap detection and show-ahead head
module sb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic push_ok, pop_ok;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop);
  assign dout = mem[rp[AW-1:0]];
  // pointer update; a pop on a full FIFO frees the slot the push lands in
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
    end
  // storage, no reset needed since empty gates every read
  always_ff @(posedge clk)
    if (push_ok) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/sb_uart_tx_slave.sv
// sb_uart_tx_slave: memory-mapped 8N1 UART transmitter on the sb slave port
module sb_uart_tx_slave
  import sb_uart_tx_slave_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DEF_DIV    = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        irq
);
  tx_state_e state, state_n;
  logic [15:0] baud_div, timer, timer_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shift, shift_n, dout;
  logic [1:0]  ctrl;
  logic        ovf, full, empty, pop, push, we, ovf_clr, ovf_set, busy, start_ok;
  logic [31:0] rd_val;
  logic        unused_bits;
  assign unused_bits = ^{addr[31:2], wdata[31:16]};
  assign we = sel && |rw;
  assign push = we && addr[1:0] == REG_TXDATA && rw[0];
  assign ovf_clr = we && addr[1:0] == REG_STATUS && rw[0] && wdata[STOP_CLR];
  assign ovf_set = push && full && !pop;
  assign busy = state != IDLE;
  assign start_ok = ctrl[0] && !empty;
  assign uart_tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;

  sb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // register file writes with byte lanes; an overflow set wins over a clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      baud_div <= DEF_DIV;
      ctrl <= 2'b0;
      ovf <= 1'b0;
    end else begin
      if (we && addr[1:0] == REG_BAUDDIV && rw[0]) baud_div[7:0] <= wdata[7:0];
      if (we && addr[1:0] == REG_BAUDDIV && rw[1]) baud_div[15:8] <= wdata[15:8];
      if (we && addr[1:0] == REG_CTRL && rw[0]) ctrl <= wdata[1:0];
      ovf <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf;
    end

  // read mux for the register addressed this cycle
  always_comb
    rd_val = addr[1:0] == REG_STATUS  ? {28'b0, ovf, busy, empty, full} :
             addr[1:0] == REG_BAUDDIV ? {16'b0, baud_div} :
             addr[1:0] == REG_CTRL    ? {30'b0, ctrl} : 32'b0;

  // registered read data and level interrupt
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rdata <= 32'b0;
      irq <= 1'b0;
    end else begin
      rdata <= (sel && rw == 4'b0) ? rd_val : 32'b0;
      irq <= empty && state == IDLE && ctrl[1];
    end

  // TX FSM state, bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      timer <= 16'b0;
      bit_idx <= 3'b0;
      shift <= 8'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      bit_idx <= bit_n;
      shift <= shift_n;
    end

  // next-state logic; STOP hands straight to START when more data waits
  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n = bit_idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE:
        if (start_ok) begin
          pop = 1'b1;
          shift_n = dout;
          timer_n = baud_div;
          state_n = START;
        end
      START:
        if (timer == 16'd0) begin
          state_n = DATA;
          timer_n = baud_div;
          bit_n = 3'd0;
        end else timer_n = timer - 16'd1;
      DATA:
        if (timer == 16'd0) begin
          timer_n = baud_div;
          if (bit_idx == 3'd7) state_n = STOP;
          else begin
            bit_n = bit_idx + 3'd1;
            shift_n = shift >> 1;
          end
        end else timer_n = timer - 16'd1;
      STOP:
        if (timer == 16'd0) begin
          if (start_ok) begin
            pop = 1'b1;
            shift_n = dout;
            timer_n = baud_div;
            state_n = START;
          end else state_n = IDLE;
        end else timer_n = timer - 16'd1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sb_uart_tx_slave.sv
// tb_sb_uart_tx_slave: directed self-checking bench for the UART TX slave
module tb_sb_uart_tx_slave;
  logic        clk, rst, sel, uart_tx, irq;
  logic [3:0]  rw;
  logic [31:0] addr, wdata, rdata, d;
  logic [9:0]  fr, fr2;
  int checks = 0;
  int passes = 0;

  sb_uart_tx_slave dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v, input logic [3:0] be);
    sel = 1'b1;
    rw = be;
    addr = {30'b0, a};
    wdata = v;
    @(negedge clk);
    sel = 1'b0;
    rw = 4'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1;
    rw = 4'b0;
    addr = {30'b0, a};
    @(negedge clk);
    v = rdata;
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    sel = 1'b0;
    rw = 4'b0;
    addr = 32'b0;
    wdata = 32'b0;
    #1;
    chk("rst_tx", uart_tx, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", irq, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd(2, d); chk("rst_baud", d, 433);
    rd(1, d); chk("rst_status", d, 32'h2);
    rd(3, d); chk("rst_ctrl", d, 0);
    // frame of 0x41 at 4 cycles per bit
    wr(2, 32'd3, 4'b0011);
    wr(3, 32'd1, 4'b0001);
    wr(0, 32'h41, 4'b0001);
    fr = 10'b1_0100_0001_0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("frame41_%0d", i), uart_tx, fr[i/4]);
    end
    @(negedge clk);
    chk("frame41_idle", uart_tx, 1);
    rd(1, d); chk("status_after41", d, 32'h2);
    // overflow with tx disabled
    wr(3, 32'd0, 4'b0001);
    for (int i = 0; i < 5; i++) wr(0, 32'h10 + i, 4'b0001);
    rd(1, d); chk("status_ovf_full", d, 32'h9);
    wr(1, 32'h8, 4'b0001);
    rd(1, d); chk("status_ovf_clr", d, 32'h1);
    @(negedge clk);
    chk("rdata_zero_after", rdata, 0);
    rd(0, d); chk("txdata_reads0", d, 0);
    // drain at 1 cycle per bit
    wr(2, 32'd0, 4'b0011);
    wr(3, 32'd1, 4'b0001);
    repeat (60) @(negedge clk);
    rd(1, d); chk("status_drained", d, 32'h2);
    wr(2, 32'hABCD_5678, 4'b0010);
    rd(2, d); chk("baud_lane1", d, 32'h5600);
    wr(2, 32'hFFFF_0003, 4'b1111);
    rd(2, d); chk("baud_upper0", d, 32'h3);
    // BAUDDIV 3->7 during data bit 2 of 0xA5
    wr(0, 32'hA5, 4'b0001);
    fr = 10'b1_1010_0101_0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk($sformatf("baudchg_%0d", i), uart_tx, fr[i < 16 ? i/4 : 4 + (i-16)/8]);
      if (i == 12) begin
        sel = 1'b1; rw = 4'b0011; addr = 32'd2; wdata = 32'd7;
      end
      if (i == 13) begin
        sel = 1'b0; rw = 4'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("baudchg_idle", uart_tx, 1);
    // back-to-back frames and irq
    wr(2, 32'd1, 4'b0011);
    wr(3, 32'd0, 4'b0001);
    wr(0, 32'h0F, 4'b0001);
    wr(0, 32'hF0, 4'b0001);
    wr(3, 32'd3, 4'b0001);
    fr = 10'b1_0000_1111_0;
    fr2 = 10'b1_1111_0000_0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_%0d", i), uart_tx, i < 20 ? fr[i/2] : fr2[(i-20)/2]);
      chk($sformatf("b2b_irq_%0d", i), irq, 0);
    end
    @(negedge clk);
    chk("irq_stop_end", irq, 0);
    chk("line_idle", uart_tx, 1);
    @(negedge clk);
    chk("irq_rise", irq, 1);
    // reset mid-frame
    sel = 1'b1; rw = 4'b0001; addr = 32'd0; wdata = 32'h00;
    @(negedge clk);
    rw = 4'b0; addr = 32'd2;
    @(negedge clk);
    chk("pre_rst_tx", uart_tx, 0);
    chk("pre_rst_rdata", rdata, 1);
    #2 rst = 1'b0;
    sel = 1'b0;
    #1;
    chk("midrst_tx", uart_tx, 1);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_irq", irq, 0);
    @(negedge clk);
    rst = 1'b1;
    rd(2, d); chk("midrst_baud", d, 433);
    rd(1, d); chk("midrst_status", d, 32'h2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
